dp2_fetch: RTL and testbench

- Parametrised second-generation fetch datapath: PC, instruction register (IR), incrementer, jump-target mux and memory-address mux (PC vs IR operand).
- Adds a fetch/data-access FSM with a memory req/ack handshake, relative and conditional jumps, and a halt state.
- Sits between program/data memory and the control unit.

---
 rtl/dp2_pkg.sv | 15 +
 rtl/dp2_fetch_ret_stack.sv | 51 +++++
 rtl/dp2_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_dp2_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dp2_pkg.sv
// Shared constants for the dp2_fetch datapath: FSM state encodings and jump modes.
package dp2_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam logic [1:0] JMP_ABS  = 2'b00;
  localparam logic [1:0] JMP_REL  = 2'b01;
  localparam logic [1:0] JMP_ZERO = 2'b10;
  localparam logic [1:0] JMP_CALL = 2'b11;

endpackage

// File: rtl/dp2_fetch_ret_stack.sv
// Return-address stack for call/return (DP2_CALL_RET_EN builds only).
// Overflowing pushes and underflowing pops are dropped; the caller flags them.
module dp2_ret_stack #(
  parameter int N     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]   r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [IW-1:0]  w_top;
  logic [IW-1:0]  w_wr;

  assign full  = (r_sp == SPW'(DEPTH));
  assign empty = (r_sp == {SPW{1'b0}});
  assign w_top = IW'(r_sp - SPW'(1));
  assign w_wr  = IW'(r_sp);
  assign dout  = empty ? {N{1'b0}} : r_mem[w_top];

  // Stack pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp <= {SPW{1'b0}};
    end else if (push && !full) begin
      r_sp <= r_sp + SPW'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - SPW'(1);
    end else begin
      r_sp <= r_sp;
    end
  end

  // Entry storage, written on an accepted push
  always_ff @(posedge clock) begin
    if (!reset && push && !full) begin
      r_mem[w_wr] <= din;
    end
  end

endmodule

// File: rtl/dp2_fetch.sv
// Fetch datapath with fetch/decode/data FSM and memory req/ack handshake.
// Define DP2_CALL_RET_EN to add call (jmp_mode 11) / return via a return stack.
module dp2_fetch
  import dp2_pkg::*;
#(
  parameter int N        = 5,
  parameter int M        = 8,
  parameter int RS_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  output logic           mem_req,
  output logic [N-1:0]   mem_addr,
  input  logic           mem_ack,
  input  logic [M-1:0]   mem_rdata,
  input  logic           jmp_en,
  input  logic [1:0]     jmp_mode,
  input  logic           zero_flag,
  input  logic           ret_en,
  input  logic           data_req,
  input  logic           halt_req,
  output logic [N-1:0]   pc,
  output logic [M-1:0]   ir,
  output logic [M-N-1:0] opcode,
  output logic [N-1:0]   operand,
  output logic           ir_valid,
  output logic [M-1:0]   data_out,
  output logic           data_valid,
  output logic           halted,
  output logic           stack_err
);

  logic [2:0]   r_state;
  logic [N-1:0] r_pc;
  logic [M-1:0] r_ir;
  logic [M-1:0] r_data_out;
  logic         r_data_valid;

  logic [2:0]   w_state_nxt;
  logic [N-1:0] w_pc_nxt;
  logic [N-1:0] w_operand;
  logic [N-1:0] w_jmp_pc;

  assign w_operand  = r_ir[N-1:0];
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign opcode     = r_ir[M-1:N];
  assign operand    = w_operand;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

`ifdef DP2_CALL_RET_EN
  logic         w_push;
  logic         w_pop;
  logic         w_err_set;
  logic         w_rs_full;
  logic         w_rs_empty;
  logic [N-1:0] w_rs_dout;
  logic         r_stack_err;

  dp2_ret_stack #(.N(N), .DEPTH(RS_DEPTH)) u_ret_stack (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_pc),
    .dout  (w_rs_dout),
    .full  (w_rs_full),
    .empty (w_rs_empty)
  );

  assign stack_err = r_stack_err;

  // Sticky stack error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stack_err <= 1'b0;
    end else if (w_err_set) begin
      r_stack_err <= 1'b1;
    end else begin
      r_stack_err <= r_stack_err;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ret_en ^ (RS_DEPTH > 0);
  assign stack_err = 1'b0;
`endif

  // Jump target; an N-bit operand sign-extended to N bits is itself, so relative is a plain modular add
  always_comb begin
    w_jmp_pc = r_pc;
    case (jmp_mode)
      JMP_ABS:  w_jmp_pc = w_operand;
      JMP_REL:  w_jmp_pc = r_pc + w_operand;
      JMP_ZERO: begin
        if (zero_flag) w_jmp_pc = w_operand;
        else           w_jmp_pc = r_pc;
      end
`ifdef DP2_CALL_RET_EN
      JMP_CALL: w_jmp_pc = w_operand;
`else
      JMP_CALL: w_jmp_pc = r_pc;
`endif
      default:  w_jmp_pc = r_pc;
    endcase
  end

  // Next state and next pc
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
`ifdef DP2_CALL_RET_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
`endif
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (mem_ack) begin
          w_state_nxt = DECODE;
          w_pc_nxt    = r_pc + {{(N-1){1'b0}}, 1'b1};
        end else begin
          w_state_nxt = FETCH;
        end
      end
      DECODE: begin
        if (halt_req) begin
          w_state_nxt = HALT;
        end else if (data_req) begin
          w_state_nxt = DATA;
        end else begin
          w_state_nxt = FETCH;
`ifdef DP2_CALL_RET_EN
          if (ret_en) begin
            if (w_rs_empty) begin
              w_err_set = 1'b1;
            end else begin
              w_pc_nxt = w_rs_dout;
              w_pop    = 1'b1;
            end
          end else if (jmp_en) begin
            w_pc_nxt = w_jmp_pc;
            if (jmp_mode == JMP_CALL) begin
              if (w_rs_full) w_err_set = 1'b1;
              else           w_push    = 1'b1;
            end else begin
              w_push = 1'b0;
            end
          end else begin
            w_pc_nxt = r_pc;
          end
`else
          if (jmp_en) w_pc_nxt = w_jmp_pc;
          else        w_pc_nxt = r_pc;
`endif
        end
      end
      DATA: begin
        if (mem_ack) w_state_nxt = FETCH;
        else         w_state_nxt = DATA;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory interface and status decoded from state
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = {N{1'b0}};
    ir_valid = 1'b0;
    halted   = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
      end
      DATA: begin
        mem_req  = 1'b1;
        mem_addr = w_operand;
      end
      DECODE:  ir_valid = 1'b1;
      HALT:    halted   = 1'b1;
      default: mem_req  = 1'b0;
    endcase
  end

  // State, pc, ir and data registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= {N{1'b0}};
      r_ir         <= {M{1'b0}};
      r_data_out   <= {M{1'b0}};
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_data_valid <= (r_state == DATA) && mem_ack;
      if ((r_state == FETCH) && mem_ack) r_ir <= mem_rdata;
      else                               r_ir <= r_ir;
      if ((r_state == DATA) && mem_ack) r_data_out <= mem_rdata;
      else                              r_data_out <= r_data_out;
    end
  end

endmodule

// File: tb/tb_dp2_fetch.sv
// Directed self-checking bench for dp2_fetch (N=5, M=8, zero-wait memory unless stalled).
module tb_dp2_fetch;

  logic       clock = 1'b0;
  logic       reset;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       jmp_en;
  logic [1:0] jmp_mode;
  logic       zero_flag;
  logic       ret_en;
  logic       data_req;
  logic       halt_req;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       ir_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       halted;
  logic       stack_err;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] e_pc;

  dp2_fetch #(.N(5), .M(8), .RS_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jmp_en(jmp_en), .jmp_mode(jmp_mode),
    .zero_flag(zero_flag), .ret_en(ret_en), .data_req(data_req), .halt_req(halt_req),
    .pc(pc), .ir(ir), .opcode(opcode), .operand(operand), .ir_valid(ir_valid),
    .data_out(data_out), .data_valid(data_valid), .halted(halted), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From FETCH with zero-wait ack: lands in DECODE
  task automatic do_fetch(input logic [7:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic do_decode(input logic h, input logic dr, input logic r,
                           input logic j, input logic [1:0] m, input logic z);
    halt_req = h; data_req = dr; ret_en = r; jmp_en = j; jmp_mode = m; zero_flag = z;
    step();
    halt_req = 1'b0; data_req = 1'b0; ret_en = 1'b0; jmp_en = 1'b0; jmp_mode = 2'b00; zero_flag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00; jmp_en = 1'b0; jmp_mode = 2'b00; zero_flag = 1'b0;
    ret_en = 1'b0; data_req = 1'b0; halt_req = 1'b0;
    do_reset();
    chk("rst_pc", pc, 0); chk("rst_ir", ir, 0); chk("rst_req", mem_req, 0);
    chk("rst_irv", ir_valid, 0); chk("rst_halt", halted, 0); chk("rst_dv", data_valid, 0);
    chk("rst_dout", data_out, 0); chk("rst_serr", stack_err, 0);

    step();  // IDLE -> FETCH
    chk("f0_req", mem_req, 1); chk("f0_addr", mem_addr, 5'h00);
    do_fetch(8'h0F);
    chk("f0_ir", ir, 8'h0F); chk("f0_opc", opcode, 3'b000); chk("f0_opd", operand, 5'h0F);
    chk("f0_pc", pc, 5'h01); chk("f0_irv", ir_valid, 1); chk("f0_dreq", mem_req, 0);
    do_decode(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("f1_irv", ir_valid, 0); chk("f1_addr", mem_addr, 5'h01);
    do_fetch(8'h0F);
    chk("f1_pc", pc, 5'h02); chk("f1_irv", ir_valid, 1);
    do_decode(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // Stall three cycles in FETCH
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_req", mem_req, 1); chk("st_addr", mem_addr, 5'h02);
      chk("st_pc", pc, 5'h02); chk("st_ir", ir, 8'h0F);
    end
    do_fetch(8'hF0);
    chk("st_ir2", ir, 8'hF0); chk("st_pc2", pc, 5'h03);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("j_abs", pc, 5'h10);

    do_fetch(8'h02);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("j_abs2", pc, 5'h02);
    do_fetch(8'h1E);
    chk("j_rel_pre", pc, 5'h03);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    chk("j_rel", pc, 5'h01);
    do_fetch(8'h1F);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    chk("j_z0", pc, 5'h02);
    do_fetch(8'h1F);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    chk("j_z1", pc, 5'h1F);
    chk("wrap_addr", mem_addr, 5'h1F);
    do_fetch(8'h00);
    chk("wrap_pc", pc, 5'h00);
    do_decode(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    do_fetch(8'h12);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
`ifdef DP2_CALL_RET_EN
    e_pc = 5'h12;
`else
    e_pc = 5'h01;
`endif
    chk("j_call", pc, e_pc); chk("j_call_serr", stack_err, 0);

    // Operand-addressed data read; a simultaneous jump is not applied
    do_fetch(8'h0A);
    e_pc = e_pc + 5'd1;
    do_decode(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("d_req", mem_req, 1); chk("d_addr", mem_addr, 5'h0A); chk("d_pc", pc, e_pc);
    chk("d_dv0", data_valid, 0);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    step();
    mem_ack = 1'b0;
    chk("d_dv", data_valid, 1); chk("d_dout", data_out, 8'h5A); chk("d_fetch", mem_addr, e_pc);
    step();
    chk("d_dv_end", data_valid, 0); chk("d_dout_hold", data_out, 8'h5A);

    // Halt wins over jump
    do_fetch(8'h07);
    e_pc = e_pc + 5'd1;
    do_decode(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("h_halt", halted, 1); chk("h_req", mem_req, 0); chk("h_pc", pc, e_pc);
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    chk("h_stay", halted, 1); chk("h_pc2", pc, e_pc);

    // Reset while stalled in FETCH
    do_reset();
    chk("r_unhalt", halted, 0);
    step();
    do_fetch(8'h0F);
    do_decode(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    chk("rw_req", mem_req, 1); chk("rw_addr", mem_addr, 5'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_req0", mem_req, 0); chk("rw_pc", pc, 0); chk("rw_ir", ir, 0);

`ifdef DP2_CALL_RET_EN
    // Return on an empty stack
    step();
    do_fetch(8'h00);
    do_decode(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("re_pc", pc, 5'h01); chk("re_serr", stack_err, 1);

    do_reset();
    step();
    do_fetch(8'h04);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    do_fetch(8'h12);
    chk("c_pc", pc, 5'h05);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    chk("c_tgt", pc, 5'h12);
    do_fetch(8'h00);
    do_decode(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("c_ret", pc, 5'h05); chk("c_serr", stack_err, 0);

    // Five nested calls from 0x11 to 0x12: the fifth overflows
    do_fetch(8'h11);
    do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      do_fetch(8'h11);
      do_decode(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
      chk("n_pc", pc, 5'h11);
      chk("n_serr", stack_err, (k == 4) ? 32'd1 : 32'd0);
    end
    do_fetch(8'h00);
    do_decode(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("n_ret", pc, 5'h12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
